id_stage: RTL and testbench
===========================

# id_stage

Parametrised LC-3b decode stage with a registered ID/EX boundary.
- Decodes the instruction from IF through `control_rom` and reads operands from an internal register file, with optional WB→ID bypass.
- Detects load-use and write-back hazards; stalls IF and inserts bubbles.
- Honours backpressure from EX and flushes from branch resolution.
- Sits between the fetch stage and the execute stage.

## Interface
Parameters:
- `WIDTH`, 16, datapath and register width
- `LINK_REG`, 7, register written by JSR/JSRR/TRAP when `destmux_sel`=1
- `BYPASS_EN`, 1, 1 = same-cycle WB data forwarded into operand read; 0 = stall instead
- `HAZARD_EN`, 1, 1 = load-use bubble insertion enabled

Ports:
- `clk`  in  1  sole clock; everything is on its rising edge
- `reset`  in  1  synchronous, active-high
- `if_valid`  in  1  IF presents an instruction
- `if_ready`  out  1  ID accepts it this cycle
- `if_inst`  in  16  instruction word
- `if_pc`  in  WIDTH  PC of the instruction
- `flush`  in  1  squash the instruction in ID and in the ID/EX register
- `wb_load`  in  1  register-file write enable
- `wb_dest`  in  3  write address
- `wb_data`  in  WIDTH  write data
- `ex_valid`  out  1  ID/EX register holds a real instruction
- `ex_ready`  in  1  EX consumes the ID/EX register this cycle
- `ex_ctrl`  out  lc3b_control_word  registered control word
- `ex_pc`  out  WIDTH  registered PC
- `ex_dest`  out  3  registered destination after destmux
- `ex_sr1_data`  out  WIDTH  registered operand A
- `ex_sr2_data`  out  WIDTH  registered operand B
- `stall_count`  out  16  saturating count of hazard stall cycles

## Operation
- Fields:
  - dest = `if_inst`[11:9]
  - sr1 = `if_inst`[8:6]
  - sr2 = `if_inst`[2:0]
  - srcA = dest when `storemux_sel`=1, else sr1
  - ex_dest = `LINK_REG` when `destmux_sel`=1, else dest
- Register file: 8 × `WIDTH`; written on the edge when `wb_load`=1.
  - `BYPASS_EN`=1: a read address equal to `wb_dest` while `wb_load`=1 returns `wb_data`.
- Advance: adv = !ex_valid | ex_ready.
- Load-use hazard (`HAZARD_EN`=1), asserted when all hold:
  - ex_valid, `ex_ctrl.mem_read` and `ex_ctrl.load_regfile` are all 1
  - and either (`use_sr1` and srcA = `ex_dest`) or (`use_sr2` and sr2 = `ex_dest`).
- WB hazard (`BYPASS_EN`=0): `wb_load` is 1 and `wb_dest` matches a used source.
- hz = if_valid & (load-use | WB hazard).
- `if_ready` = flush | (adv & !hz).
- ID/EX update, priority order:
  1. `flush`: ex_valid←0. The IF instruction offered that cycle is accepted and dropped.
  2. adv & if_valid & !hz: load the decoded instruction; ex_valid←1.
  3. adv & (hz | !if_valid): bubble, ex_valid←0; data fields hold.
  4. !adv: hold everything.
- `stall_count` increments when if_valid & !if_ready & !flush. Saturates at 16'hFFFF.
- Reset:
  - ex_valid, ex_ctrl, ex_pc, ex_dest, ex_sr1_data, ex_sr2_data and stall_count all go to 0.
  - All eight registers clear to 0.
  - if_ready is 1 in the cycle after reset.

## Timing
- Latency: an instruction accepted at edge N is visible on the ex_* outputs after edge N.
- Load-use costs exactly one bubble: the consumer is accepted on the edge after the load leaves ID/EX.
- WB write at edge N is readable from the register array from cycle N+1.
- `BYPASS_EN`=0 stalls for exactly one cycle.
- `flush` together with `ex_ready`=0 still clears ex_valid.
- `flush` together with `reset`: reset wins.
- Simultaneous hazard and `ex_ready`=0: stall, no bubble. ID/EX holds and is not overwritten.
- `reset` asserted mid-stall clears state; the stalled instruction must be re-presented.

## Structure
- `lc3b_types` holds `lc3b_word` and `lc3b_reg`.
- `lc3b_types` also holds `lc3b_control_word`, which gains the fields `use_sr1`, `use_sr2`, `mem_read` and `load_regfile` alongside `destmux_sel` and `storemux_sel`.
- Existing `control_rom` supplies those fields.
- One new sub-module, `regfile_bypass`: 8×`WIDTH` array, two read ports, one write port, synchronous clear, and a `BYPASS_EN` write-through generate.
- Hazard logic, muxes, ID/EX register and counter live in `id_stage`.

## Test plan
- Reset, then ADD R1←R2+R3 with R2=5, R3=7 written earlier, `ex_ready`=1 → next cycle ex_valid=1, ex_sr1_data=5, ex_sr2_data=7, ex_dest=1.
- LDR R4 followed by ADD R5←R4+R1 → one cycle with `if_ready`=0 and a bubble (ex_valid=0); ADD lands next cycle; `stall_count`=1.
- `wb_load`=1, `wb_dest`=2, `wb_data`=16'h1234 in the same cycle ID reads R2:
  - `BYPASS_EN`=1 → ex_sr1_data=16'h1234 with no stall
  - `BYPASS_EN`=0 → one stall, then 16'h1234.
- Hold `ex_ready`=0 for 3 cycles with a valid instruction in ID → ex_* stable, `if_ready`=0, `stall_count` unchanged.
- `flush` while ID/EX is valid and `ex_ready`=0 → ex_valid=0 next cycle; the offered instruction is dropped.
- JSR → ex_dest=7; STR R3,R6,#0 → operand A reads R3 via storemux.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the decode slice: word/register aliases, opcodes and
// the control word that travels through the ID/EX boundary.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic       use_sr1;
    logic       use_sr2;
    logic       storemux_sel;
    logic       destmux_sel;
    logic       sr2mux_sel;
  } lc3b_control_word;

  // True when a source port is actually consumed and addresses the given register.
  function automatic logic src_hit(input logic used, input lc3b_reg addr, input lc3b_reg target);
    return used && (addr == target);
  endfunction

endpackage

// File: rtl/control_rom.sv
// Combinational LC-3b decoder: opcode plus the two mode bits that change
// which sources an instruction reads.
module control_rom
  import lc3b_types::*;
(
  input  logic [3:0]       opcode,
  input  logic             jsr_mode,
  input  logic             imm_mode,
  output lc3b_control_word ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.opcode = lc3b_opcode'(opcode);
    case (lc3b_opcode'(opcode))
      op_add, op_and: begin
        ctrl.load_regfile = 1'b1;
        ctrl.use_sr1      = 1'b1;
        ctrl.use_sr2      = !imm_mode;
        ctrl.sr2mux_sel   = imm_mode;
      end
      op_not, op_shf: begin
        ctrl.load_regfile = 1'b1;
        ctrl.use_sr1      = 1'b1;
      end
      op_ldr, op_ldb, op_ldi: begin
        ctrl.load_regfile = 1'b1;
        ctrl.mem_read     = 1'b1;
        ctrl.use_sr1      = 1'b1;
      end
      // Stores steer the source-register field onto operand A.
      op_str, op_stb, op_sti: begin
        ctrl.mem_write    = 1'b1;
        ctrl.use_sr1      = 1'b1;
        ctrl.storemux_sel = 1'b1;
      end
      op_jsr: begin
        ctrl.load_regfile = 1'b1;
        ctrl.destmux_sel  = 1'b1;
        ctrl.use_sr1      = !jsr_mode;
      end
      op_trap: begin
        ctrl.load_regfile = 1'b1;
        ctrl.destmux_sel  = 1'b1;
      end
      op_jmp: ctrl.use_sr1      = 1'b1;
      op_lea: ctrl.load_regfile = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_bypass.sv
// 8-entry register file, two combinational read ports, one write port, with an
// optional write-through path so a same-cycle write is visible to readers.
module regfile_bypass
  import lc3b_types::*;
#(
  parameter int WIDTH     = 16,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  lc3b_reg          wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  lc3b_reg          rd_addr_a,
  input  lc3b_reg          rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] regs [8];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  generate
    if (BYPASS_EN) begin : g_bypass
      assign rd_data_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
      assign rd_data_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
    end else begin : g_direct
      assign rd_data_a = regs[rd_addr_a];
      assign rd_data_b = regs[rd_addr_b];
    end
  endgenerate

endmodule

// File: rtl/id_stage.sv
// LC-3b decode stage: decode, operand read, load-use / write-back hazard
// handling and the registered ID/EX boundary with backpressure and flush.
module id_stage
  import lc3b_types::*;
#(
  parameter int      WIDTH     = 16,
  parameter lc3b_reg LINK_REG  = 3'd7,
  parameter bit      BYPASS_EN = 1'b1,
  parameter bit      HAZARD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [15:0]      if_inst,
  input  logic [WIDTH-1:0] if_pc,
  input  logic             flush,
  input  logic             wb_load,
  input  logic [2:0]       wb_dest,
  input  logic [WIDTH-1:0] wb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output lc3b_control_word ex_ctrl,
  output logic [WIDTH-1:0] ex_pc,
  output logic [2:0]       ex_dest,
  output logic [WIDTH-1:0] ex_sr1_data,
  output logic [WIDTH-1:0] ex_sr2_data,
  output logic [15:0]      stall_count
);

  lc3b_control_word ctrl;
  lc3b_reg          dest, sr1, sr2, src_a;
  logic [WIDTH-1:0] sr1_data, sr2_data;
  logic             adv, load_use, wb_hazard, hz, accept;
  logic             unused_inst_bits;

  logic             ex_valid_reg;
  lc3b_control_word ex_ctrl_reg;
  logic [WIDTH-1:0] ex_pc_reg, ex_sr1_data_reg, ex_sr2_data_reg;
  lc3b_reg          ex_dest_reg;
  logic [15:0]      stall_count_reg;

  control_rom u_control_rom (
    .opcode   (if_inst[15:12]),
    .jsr_mode (if_inst[11]),
    .imm_mode (if_inst[5]),
    .ctrl     (ctrl)
  );

  assign dest  = if_inst[11:9];
  assign sr1   = if_inst[8:6];
  assign sr2   = if_inst[2:0];
  assign src_a = ctrl.storemux_sel ? dest : sr1;
  assign unused_inst_bits = ^if_inst[4:3];

  regfile_bypass #(
    .WIDTH     (WIDTH),
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wb_load),
    .wr_addr   (wb_dest),
    .wr_data   (wb_data),
    .rd_addr_a (src_a),
    .rd_addr_b (sr2),
    .rd_data_a (sr1_data),
    .rd_data_b (sr2_data)
  );

  assign adv = !ex_valid_reg || ex_ready;

  // A load still sitting in ID/EX has no data yet; its consumer must wait a cycle.
  assign load_use = HAZARD_EN && ex_valid_reg && ex_ctrl_reg.mem_read && ex_ctrl_reg.load_regfile
                 && (src_hit(ctrl.use_sr1, src_a, ex_dest_reg) || src_hit(ctrl.use_sr2, sr2, ex_dest_reg));

  assign wb_hazard = !BYPASS_EN && wb_load
                  && (src_hit(ctrl.use_sr1, src_a, wb_dest) || src_hit(ctrl.use_sr2, sr2, wb_dest));

  assign hz       = if_valid && (load_use || wb_hazard);
  assign accept   = adv && if_valid && !hz;
  assign if_ready = flush || (adv && !hz);

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg    <= 1'b0;
      ex_ctrl_reg     <= '0;
      ex_pc_reg       <= '0;
      ex_dest_reg     <= '0;
      ex_sr1_data_reg <= '0;
      ex_sr2_data_reg <= '0;
      stall_count_reg <= '0;
    end else begin
      if (flush) begin
        ex_valid_reg <= 1'b0;
      end else if (accept) begin
        ex_valid_reg    <= 1'b1;
        ex_ctrl_reg     <= ctrl;
        ex_pc_reg       <= if_pc;
        ex_dest_reg     <= ctrl.destmux_sel ? LINK_REG : dest;
        ex_sr1_data_reg <= sr1_data;
        ex_sr2_data_reg <= sr2_data;
      end else if (adv) begin
        ex_valid_reg <= 1'b0;
      end

      if (if_valid && !if_ready && !flush && stall_count_reg != 16'hFFFF)
        stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign ex_valid    = ex_valid_reg;
  assign ex_ctrl     = ex_ctrl_reg;
  assign ex_pc       = ex_pc_reg;
  assign ex_dest     = ex_dest_reg;
  assign ex_sr1_data = ex_sr1_data_reg;
  assign ex_sr2_data = ex_sr2_data_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a bypassing instance and a stalling (no bypass)
// instance share stimulus; each scenario task checks its own expectations.
module tb_id_stage;
  import lc3b_types::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             if_valid;
  logic [15:0]      if_inst;
  logic [15:0]      if_pc;
  logic             flush;
  logic             wb_load;
  logic [2:0]       wb_dest;
  logic [15:0]      wb_data;
  logic             ex_ready;

  logic             if_ready, ex_valid;
  lc3b_control_word ex_ctrl;
  logic [15:0]      ex_pc, ex_sr1_data, ex_sr2_data, stall_count;
  logic [2:0]       ex_dest;

  logic             if_ready_nb, ex_valid_nb;
  lc3b_control_word ex_ctrl_nb;
  logic [15:0]      ex_pc_nb, ex_sr1_data_nb, ex_sr2_data_nb, stall_count_nb;
  logic [2:0]       ex_dest_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
    .if_pc(if_pc), .flush(flush), .wb_load(wb_load), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_dest(ex_dest),
    .ex_sr1_data(ex_sr1_data), .ex_sr2_data(ex_sr2_data), .stall_count(stall_count)
  );

  id_stage #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready_nb), .if_inst(if_inst),
    .if_pc(if_pc), .flush(flush), .wb_load(wb_load), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_valid(ex_valid_nb), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl_nb), .ex_pc(ex_pc_nb), .ex_dest(ex_dest_nb),
    .ex_sr1_data(ex_sr1_data_nb), .ex_sr2_data(ex_sr2_data_nb), .stall_count(stall_count_nb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0; flush = 1'b0;
    wb_load = 1'b0; wb_dest = '0; wb_data = '0; ex_ready = 1'b1;
    step(); step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0b want 0", ex_valid); end
    checks++; if (ex_pc !== 16'h0000) begin errors++; $display("FAIL reset_ex_pc got %h want 0000", ex_pc); end
    checks++; if (ex_dest !== 3'd0) begin errors++; $display("FAIL reset_ex_dest got %0d want 0", ex_dest); end
    checks++; if (ex_ctrl !== lc3b_control_word'(0)) begin errors++; $display("FAIL reset_ex_ctrl got %h want 0", ex_ctrl); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_count); end
    reset = 1'b0;
    step();
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %0b want 1", if_ready); end
    $display("reset: ex_valid=%0b if_ready=%0b stall=%0d", ex_valid, if_ready, stall_count);
  endtask

  task automatic test_add();
    wb_load = 1'b1;
    wb_dest = 3'd2; wb_data = 16'h0005; step();
    wb_dest = 3'd3; wb_data = 16'h0007; step();
    wb_dest = 3'd1; wb_data = 16'h0011; step();
    wb_dest = 3'd6; wb_data = 16'h0060; step();
    wb_load = 1'b0;
    if_valid = 1'b1; if_inst = 16'h1283; if_pc = 16'h3000; ex_ready = 1'b1;  // ADD R1,R2,R3
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL add_if_ready got %0b want 1", if_ready); end
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", ex_valid); end
    checks++; if (ex_sr1_data !== 16'h0005) begin errors++; $display("FAIL add_sr1 got %h want 0005", ex_sr1_data); end
    checks++; if (ex_sr2_data !== 16'h0007) begin errors++; $display("FAIL add_sr2 got %h want 0007", ex_sr2_data); end
    checks++; if (ex_dest !== 3'd1) begin errors++; $display("FAIL add_dest got %0d want 1", ex_dest); end
    checks++; if (ex_pc !== 16'h3000) begin errors++; $display("FAIL add_pc got %h want 3000", ex_pc); end
    if_valid = 1'b0;
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL add_bubble got %0b want 0", ex_valid); end
    $display("add: sr1=%h sr2=%h dest=%0d", 16'h0005, 16'h0007, 1);
  endtask

  task automatic test_load_use();
    if_valid = 1'b1; if_inst = 16'h6840; if_pc = 16'h3002;  // LDR R4,R1,#0
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL lu_ldr_valid got %0b want 1", ex_valid); end
    checks++; if (ex_dest !== 3'd4) begin errors++; $display("FAIL lu_ldr_dest got %0d want 4", ex_dest); end
    checks++; if (ex_ctrl.mem_read !== 1'b1) begin errors++; $display("FAIL lu_ldr_mem_read got %0b want 1", ex_ctrl.mem_read); end
    if_inst = 16'h1B01; if_pc = 16'h3004;  // ADD R5,R4,R1
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL lu_if_ready got %0b want 0", if_ready); end
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0b want 0", ex_valid); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_stall got %0d want 1", stall_count); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %0b want 1", if_ready); end
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL lu_add_valid got %0b want 1", ex_valid); end
    checks++; if (ex_dest !== 3'd5) begin errors++; $display("FAIL lu_add_dest got %0d want 5", ex_dest); end
    checks++; if (ex_sr2_data !== 16'h0011) begin errors++; $display("FAIL lu_add_sr2 got %h want 0011", ex_sr2_data); end
    checks++; if (ex_pc !== 16'h3004) begin errors++; $display("FAIL lu_add_pc got %h want 3004", ex_pc); end
    if_valid = 1'b0;
    $display("load_use: stall=%0d dest=%0d", stall_count, ex_dest);
  endtask

  task automatic test_bypass();
    if_valid = 1'b1; if_inst = 16'h1C82; if_pc = 16'h3006;  // ADD R6,R2,R2
    wb_load = 1'b1; wb_dest = 3'd2; wb_data = 16'h1234;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL byp_if_ready got %0b want 1", if_ready); end
    checks++; if (if_ready_nb !== 1'b0) begin errors++; $display("FAIL nb_if_ready got %0b want 0", if_ready_nb); end
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL byp_valid got %0b want 1", ex_valid); end
    checks++; if (ex_sr1_data !== 16'h1234) begin errors++; $display("FAIL byp_sr1 got %h want 1234", ex_sr1_data); end
    checks++; if (ex_sr2_data !== 16'h1234) begin errors++; $display("FAIL byp_sr2 got %h want 1234", ex_sr2_data); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL byp_stall got %0d want 1", stall_count); end
    checks++; if (ex_valid_nb !== 1'b0) begin errors++; $display("FAIL nb_bubble got %0b want 0", ex_valid_nb); end
    checks++; if (stall_count_nb !== 16'd2) begin errors++; $display("FAIL nb_stall got %0d want 2", stall_count_nb); end
    wb_load = 1'b0;
    #1;
    checks++; if (if_ready_nb !== 1'b1) begin errors++; $display("FAIL nb_release got %0b want 1", if_ready_nb); end
    step();
    checks++; if (ex_valid_nb !== 1'b1) begin errors++; $display("FAIL nb_valid got %0b want 1", ex_valid_nb); end
    checks++; if (ex_sr1_data_nb !== 16'h1234) begin errors++; $display("FAIL nb_sr1 got %h want 1234", ex_sr1_data_nb); end
    checks++; if (ex_sr1_data !== 16'h1234) begin errors++; $display("FAIL byp_written got %h want 1234", ex_sr1_data); end
    if_valid = 1'b0;
    $display("bypass: byp_sr1=%h nb_sr1=%h nb_stall=%0d", ex_sr1_data, ex_sr1_data_nb, stall_count_nb);
  endtask

  task automatic test_backpressure();
    if_valid = 1'b1; if_inst = 16'h4800; if_pc = 16'h3010; ex_ready = 1'b1;  // JSR #0
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL jsr_valid got %0b want 1", ex_valid); end
    checks++; if (ex_dest !== 3'd7) begin errors++; $display("FAIL jsr_dest got %0d want 7", ex_dest); end
    if_valid = 1'b0; ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL bp_if_ready[%0d] got %0b want 0", i, if_ready); end
      step();
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0b want 1", i, ex_valid); end
      checks++; if (ex_pc !== 16'h3010) begin errors++; $display("FAIL bp_pc[%0d] got %h want 3010", i, ex_pc); end
      checks++; if (ex_dest !== 3'd7) begin errors++; $display("FAIL bp_dest[%0d] got %0d want 7", i, ex_dest); end
      checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL bp_stall[%0d] got %0d want 1", i, stall_count); end
      $display("backpressure cycle %0d: ex_valid=%0b pc=%h", i, ex_valid, ex_pc);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; if_valid = 1'b1; if_inst = 16'h1283; if_pc = 16'h3020;  // ex_ready still 0
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fl_if_ready got %0b want 1", if_ready); end
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %0b want 0", ex_valid); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL fl_stall got %0d want 1", stall_count); end
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL fl_dropped got %0b want 0", ex_valid); end
    $display("flush: ex_valid=%0b", ex_valid);
  endtask

  task automatic test_store();
    if_valid = 1'b1; if_inst = 16'h7680; if_pc = 16'h3030;  // STR R3,R6,#0
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL str_valid got %0b want 1", ex_valid); end
    checks++; if (ex_sr1_data !== 16'h0007) begin errors++; $display("FAIL str_srcA got %h want 0007", ex_sr1_data); end
    checks++; if (ex_ctrl.mem_write !== 1'b1) begin errors++; $display("FAIL str_mem_write got %0b want 1", ex_ctrl.mem_write); end
    if_valid = 1'b0;
    step();
    $display("store: srcA=%h", 16'h0007);
  endtask

  task automatic test_hazard_backpressure();
    if_valid = 1'b1; if_inst = 16'h6840; if_pc = 16'h3040;
    step();
    ex_ready = 1'b0; if_inst = 16'h1B01; if_pc = 16'h3042;
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL hbp_if_ready got %0b want 0", if_ready); end
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL hbp_hold_valid got %0b want 1", ex_valid); end
    checks++; if (ex_pc !== 16'h3040) begin errors++; $display("FAIL hbp_hold_pc got %h want 3040", ex_pc); end
    checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL hbp_stall got %0d want 2", stall_count); end
    ex_ready = 1'b1;
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL hbp_bubble got %0b want 0", ex_valid); end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL hbp_stall2 got %0d want 3", stall_count); end
    step();
    checks++; if (ex_pc !== 16'h3042) begin errors++; $display("FAIL hbp_add_pc got %h want 3042", ex_pc); end
    if_valid = 1'b0;
    $display("hazard_backpressure: stall=%0d pc=%h", stall_count, ex_pc);
  endtask

  task automatic test_reset_mid_stall();
    if_valid = 1'b1; if_inst = 16'h6840; if_pc = 16'h3050;
    step();
    if_inst = 16'h1B01;
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL rms_if_ready got %0b want 0", if_ready); end
    reset = 1'b1;
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rms_valid got %0b want 0", ex_valid); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rms_stall got %0d want 0", stall_count); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL rms_if_ready2 got %0b want 1", if_ready); end
    reset = 1'b0; if_inst = 16'h1283; if_pc = 16'h3060;
    step();
    checks++; if (ex_sr1_data !== 16'h0000) begin errors++; $display("FAIL rms_rf_clear_a got %h want 0000", ex_sr1_data); end
    checks++; if (ex_sr2_data !== 16'h0000) begin errors++; $display("FAIL rms_rf_clear_b got %h want 0000", ex_sr2_data); end
    if_valid = 1'b0;
    $display("reset_mid_stall: ex_valid=%0b stall=%0d", ex_valid, stall_count);
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_bypass();
    test_backpressure();
    test_flush();
    test_store();
    test_hazard_backpressure();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
